// File: rtl/ias_core_p.sv
// ias_core_p: handshaked IAS-style accumulator datapath with word memory, MQ, flags and debug read port
// Ports: clk, reset (synchronous, active high)
//        instr_valid/instr_ready handshake carrying opcode, address, data_in
//        data_out = AC, mq_out = MQ, done = one-cycle retire pulse, carry/zero/err status flags
//        dbg_addr -> dbg_data combinational memory peek (0 when out of range)
module ias_core_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] mq_out,
    output logic              done,
    output logic              carry,
    output logic              zero,
    output logic              err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, DONE} state_t;

    state_t              state;
    logic [3:0]          ir;
    logic [ADDR_W-1:0]   mar;
    logic [DATA_W-1:0]   mbr, mdr, ac, mq;
    logic                bad;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [IW-1:0]       idx;
    logic                in_rng, uses_mem, writes_ac;
    logic [DATA_W:0]     sum, dif;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   ac_n, mq_n;
    logic                c_n;

    assign idx       = mar[IW-1:0];
    assign in_rng    = 32'(mar) < DEPTH;
    assign uses_mem  = ir inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
    assign writes_ac = ir inside {4'd1, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10};
    assign sum       = {1'b0, ac} + {1'b0, mdr};
    // top bit of the extended difference is the borrow
    assign dif       = {1'b0, ac} - {1'b0, mdr};
    assign prod      = (2*DATA_W)'(mq) * (2*DATA_W)'(mdr);
    assign data_out  = ac;
    assign mq_out    = mq;
    assign dbg_data  = 32'(dbg_addr) < DEPTH ? mem[dbg_addr[IW-1:0]] : '0;

    always_comb begin
        ac_n = ac;
        mq_n = mq;
        c_n  = carry;
        case (ir)
            4'd1:    begin ac_n = mdr; c_n = 1'b0; end
            4'd3:    {c_n, ac_n} = sum;
            4'd4:    {c_n, ac_n} = dif;
            4'd6:    begin ac_n = mbr; c_n = 1'b0; end
            4'd7:    mq_n = mdr;
            4'd8:    begin {ac_n, mq_n} = prod; c_n = 1'b0; end
            4'd9:    {c_n, ac_n} = {ac, 1'b0};
            4'd10:   {ac_n, c_n} = {1'b0, ac};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            done        <= 1'b0;
            ac          <= '0;
            mq          <= '0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            err         <= 1'b0;
            ir          <= '0;
            mar         <= '0;
            mbr         <= '0;
            mdr         <= '0;
            bad         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (instr_valid) begin
                    ir          <= opcode;
                    mar         <= address;
                    mbr         <= data_in;
                    instr_ready <= 1'b0;
                    state       <= DECODE;
                end
                DECODE: begin
                    bad   <= ir > 4'd10 || (uses_mem && !in_rng);
                    state <= READ;
                end
                READ: begin
                    mdr   <= in_rng ? mem[idx] : '0;
                    state <= EXEC;
                end
                EXEC: begin
                    // an erroring instruction only updates err
                    err <= bad;
                    if (!bad) begin
                        ac    <= ac_n;
                        mq    <= mq_n;
                        carry <= c_n;
                        if (writes_ac) zero <= ac_n == '0;
                        if (ir == 4'd2 || ir == 4'd5) mem[idx] <= ir == 4'd2 ? ac : mbr;
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ias_core_p.sv
// tb_ias_core_p: scoreboard bench running a default-depth and a 16-word core in lockstep
module tb_ias_core_p;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [3:0] opcode = '0;
    logic [7:0] address = '0, data_in = '0, dbg_addr = '0;

    logic       ready0, done0, carry0, zero0, err0;
    logic       ready1, done1, carry1, zero1, err1;
    logic [7:0] dout0, mq0, dbg0, dout1, mq1, dbg1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int ac;
        int mq;
        int dbg;
        int due;
        bit c;
        bit z;
        bit e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int m_mem[2][256];
    int m_ac[2], m_mq[2];
    bit m_c[2], m_z[2], m_e[2];
    int dep[2];

    ias_core_p u0 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(ready0),
        .opcode(opcode), .address(address), .data_in(data_in), .data_out(dout0),
        .mq_out(mq0), .done(done0), .carry(carry0), .zero(zero0), .err(err0),
        .dbg_addr(dbg_addr), .dbg_data(dbg0)
    );

    ias_core_p #(.DEPTH(16)) u1 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(ready1),
        .opcode(opcode), .address(address), .data_in(data_in), .data_out(dout1),
        .mq_out(mq1), .done(done1), .carry(carry1), .zero(zero1), .err(err1),
        .dbg_addr(dbg_addr), .dbg_data(dbg1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1);
    end

    task automatic cmp(input string name, input int u, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", name, u, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < 256; a++) m_mem[u][a] = 0;
            m_ac[u] = 0;
            m_mq[u] = 0;
            m_c[u] = 0;
            m_z[u] = 0;
            m_e[u] = 0;
        end
    endtask

    // architectural effect of one instruction on unit u, in plain integer arithmetic
    task automatic model(input int u, input int op, input int a, input int d);
        int m;
        bit bad;
        bad = op > 10 || (a >= dep[u] && op inside {1, 2, 3, 4, 5, 7, 8});
        m = a < dep[u] ? m_mem[u][a] : 0;
        m_e[u] = bad;
        if (bad) return;
        case (op)
            1: begin m_ac[u] = m; m_c[u] = 0; end
            2: m_mem[u][a] = m_ac[u];
            3: begin m_c[u] = (m_ac[u] + m) > 255; m_ac[u] = (m_ac[u] + m) % 256; end
            4: begin m_c[u] = m_ac[u] < m; m_ac[u] = (m_ac[u] - m + 256) % 256; end
            5: m_mem[u][a] = d;
            6: begin m_ac[u] = d; m_c[u] = 0; end
            7: m_mq[u] = m;
            8: begin m = m_mq[u] * m; m_ac[u] = m / 256; m_mq[u] = m % 256; m_c[u] = 0; end
            9: begin m_c[u] = m_ac[u] >= 128; m_ac[u] = (m_ac[u] * 2) % 256; end
            10: begin m_c[u] = (m_ac[u] % 2) == 1; m_ac[u] = m_ac[u] / 2; end
            default: ;
        endcase
        if (op inside {1, 3, 4, 6, 8, 9, 10}) m_z[u] = m_ac[u] == 0;
    endtask

    // called at the negedge before the accepting edge; done is due four cycles later
    task automatic push(input int op, input int a, input int d);
        exp_t x;
        for (int u = 0; u < 2; u++) begin
            model(u, op, a, d);
            x.ac = m_ac[u];
            x.mq = m_mq[u];
            x.c = m_c[u];
            x.z = m_z[u];
            x.e = m_e[u];
            x.dbg = a < dep[u] ? m_mem[u][a] : 0;
            x.due = cyc + 4;
            if (u == 0) q0.push_back(x);
            else q1.push_back(x);
        end
    endtask

    task automatic check(input int u, input int ac, input int mq, input int dbg,
                         input bit c, input bit z, input bit e);
        exp_t x;
        if (u == 0 && q0.size() == 0 || u == 1 && q1.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done dut%0d: got done=1, expected no pending instruction (cycle %0d)", u, cyc);
            return;
        end
        if (u == 0) x = q0.pop_front();
        else x = q1.pop_front();
        cmp("done_latency", u, cyc, x.due);
        cmp("ac", u, ac, x.ac);
        cmp("mq", u, mq, x.mq);
        cmp("mem", u, dbg, x.dbg);
        cmp("carry", u, c, x.c);
        cmp("zero", u, z, x.z);
        cmp("err", u, e, x.e);
    endtask

    always @(negedge clk) if (!reset && done0) check(0, dout0, mq0, dbg0, carry0, zero0, err0);
    always @(negedge clk) if (!reset && done1) check(1, dout1, mq1, dbg1, carry1, zero1, err1);

    task automatic issue(input int op, input int a, input int d);
        int n = 0;
        while (!ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready0) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got instr_ready=0, expected 1 within 50 cycles");
            return;
        end
        instr_valid = 1'b1;
        opcode = 4'(op);
        address = 8'(a);
        data_in = 8'(d);
        dbg_addr = 8'(a);
        push(op, a, d);
        @(negedge clk);
        instr_valid = 1'b0;
        opcode = 4'($urandom);
        address = 8'($urandom);
        data_in = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !ready0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", q0.size(), q1.size());
        end
    endtask

    initial begin
        dep[0] = 256;
        dep[1] = 16;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        cmp("rst_ready", 0, ready0, 1);
        cmp("rst_ac", 0, dout0, 0);
        cmp("rst_mq", 0, mq0, 0);
        cmp("rst_flags", 0, {carry0, zero0, err0, done0}, 0);
        cmp("rst_mem", 0, dbg0, 0);

        issue(5, 1, 25); issue(5, 2, 50); issue(1, 1, 0); issue(3, 2, 0); issue(2, 3, 0);
        drain();
        dbg_addr = 8'd3;
        #1;
        cmp("t1_mem3", 0, dbg0, 75);
        cmp("t1_ac", 0, dout0, 75);
        cmp("t1_cz", 0, {carry0, zero0}, 0);

        issue(6, 0, 200); issue(5, 10, 100); issue(3, 10, 0);
        drain();
        cmp("t2_add_ac", 0, dout0, 44);
        cmp("t2_add_c", 0, carry0, 1);
        issue(5, 11, 44); issue(4, 11, 0);
        drain();
        cmp("t2_sub0_zc", 0, {zero0, carry0}, 2);
        issue(5, 12, 20); issue(4, 12, 0);
        drain();
        cmp("t2_subb_ac", 0, dout0, 236);
        cmp("t2_subb_c", 0, carry0, 1);

        issue(5, 5, 13); issue(5, 6, 20); issue(7, 6, 0); issue(8, 5, 0);
        drain();
        cmp("t3_mul_ac", 0, dout0, 1);
        cmp("t3_mul_mq", 0, mq0, 4);
        issue(10, 0, 0);
        drain();
        cmp("t3_shr", 0, {dout0, carry0, zero0}, 3);

        issue(6, 0, 9); issue(12, 7, 0);
        drain();
        cmp("t4_err", 0, err0, 1);
        cmp("t4_ac", 0, dout0, 9);
        issue(6, 0, 3);
        drain();
        cmp("t4_clr", 0, {err0, dout0}, 3);

        issue(5, 20, 77);
        drain();
        cmp("t5_err16", 1, err1, 1);
        dbg_addr = 8'd4;
        #1;
        cmp("t5_alias", 1, dbg1, 0);
        issue(5, 15, 77);
        drain();
        dbg_addr = 8'd15;
        #1;
        cmp("t5_top", 1, dbg1, 77);

        for (int k = 0; k < 200; k++)
            issue($urandom_range(0, 12), $urandom_range(0, 31), $urandom_range(0, 255));
        drain();

        // valid held high: ready only every fifth cycle, busy-cycle inputs ignored
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmp("hs_ready", 0, ready0, 1);
            opcode = 4'd0;
            address = 8'($urandom_range(0, 31));
            dbg_addr = address;
            push(0, address, 0);
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                cmp("hs_busy", 0, ready0, 0);
                opcode = 4'd6;
                data_in = 8'($urandom);
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        drain();

        issue(6, 0, 75);
        drain();
        instr_valid = 1'b1;
        opcode = 4'd2;
        address = 8'd3;
        dbg_addr = 8'd3;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cmp("rs_ready", 0, ready0, 1);
        cmp("rs_ac", 0, dout0, 0);
        cmp("rs_mem3", 0, dbg0, 0);
        cmp("rs_done", 0, done0, 0);
        issue(1, 3, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
